// File: rtl/aes128_stream_feeder.sv
// Byte-stream front/back end for the aes128 core: packs bytes into blocks,
// launches the core, waits on its ready handshake and streams the result out.
module aes128_stream_feeder #(
    parameter int WAIT_LIMIT = 255,
    parameter int WAIT_W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_decipher_i,
    input  logic [3:0]   cfg_mode_i,
    input  logic [127:0] cfg_key_i,
    input  logic [127:0] cfg_iv_i,
    input  logic [15:0]  cfg_segment_len_i,
    input  logic         s_valid_i,
    input  logic [7:0]   s_data_i,
    input  logic         s_last_i,
    output logic         s_ready_o,
    output logic         m_valid_o,
    output logic [7:0]   m_data_o,
    output logic         m_last_o,
    input  logic         m_ready_i,
    output logic         aes_cipher_en_o,
    output logic         aes_decipher_en_o,
    output logic         aes_chain_en_o,
    output logic [127:0] aes_data_in_o,
    output logic [127:0] aes_key_o,
    output logic [3:0]   aes_mode_o,
    output logic [127:0] aes_init_vector_o,
    output logic [15:0]  aes_segment_len_o,
    input  logic [127:0] aes_data_out_i,
    input  logic         aes_ready_i,
    output logic         busy_o,
    output logic         err_o
);

    typedef enum logic [2:0] {
        FILL, CLR, LAUNCH, WAIT, DRAIN, ERR
    } state_t;

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(WAIT_LIMIT);

    state_t            state_q, state_d;
    logic [3:0]        byte_cnt_q, byte_cnt_d;
    logic [3:0]        out_idx_q, out_idx_d;
    logic [4:0]        nbytes_q, nbytes_d;
    logic              first_blk_q, first_blk_d;
    logic              blk_last_q, blk_last_d;
    logic              dec_q, dec_d;
    logic              chain_q, chain_d;
    logic              ready_q;
    logic              err_q, err_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [127:0]      data_q, data_d;
    logic [127:0]      key_q, key_d;
    logic [127:0]      iv_q, iv_d;
    logic [127:0]      result_q, result_d;
    logic [3:0]        mode_q, mode_d;
    logic [15:0]       seg_q, seg_d;
    logic              out_end;

    assign out_end = ({1'b0, out_idx_q} == nbytes_q - 5'd1);

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        out_idx_d   = out_idx_q;
        nbytes_d    = nbytes_q;
        first_blk_d = first_blk_q;
        blk_last_d  = blk_last_q;
        dec_d       = dec_q;
        chain_d     = chain_q;
        err_d       = err_q;
        wait_cnt_d  = wait_cnt_q;
        data_d      = data_q;
        key_d       = key_q;
        iv_d        = iv_q;
        result_d    = result_q;
        mode_d      = mode_q;
        seg_d       = seg_q;
        s_ready_o         = 1'b0;
        m_valid_o         = 1'b0;
        aes_cipher_en_o   = 1'b0;
        aes_decipher_en_o = 1'b0;
        unique case (state_q)
            FILL: begin
                s_ready_o = 1'b1;
                if (s_valid_i) begin
                    if (byte_cnt_q == 4'd0) data_d = '0;
                    data_d[7'd127 - {byte_cnt_q, 3'b000} -: 8] = s_data_i;
                    // Config is frozen for the whole message
                    if (byte_cnt_q == 4'd0 && first_blk_q) begin
                        dec_d  = cfg_decipher_i;
                        mode_d = cfg_mode_i;
                        key_d  = cfg_key_i;
                        iv_d   = cfg_iv_i;
                        seg_d  = cfg_segment_len_i;
                    end
                    if (byte_cnt_q == 4'd15 || s_last_i) begin
                        nbytes_d   = {1'b0, byte_cnt_q} + 5'd1;
                        blk_last_d = s_last_i;
                        byte_cnt_d = 4'd0;
                        state_d    = first_blk_q ? CLR : LAUNCH;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end
            end
            CLR: state_d = LAUNCH;
            LAUNCH: begin
                aes_cipher_en_o   = ~dec_q;
                aes_decipher_en_o = dec_q;
                chain_d    = 1'b1;
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (aes_ready_i && !ready_q) begin
                    result_d  = aes_data_out_i;
                    out_idx_d = 4'd0;
                    state_d   = DRAIN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_d == LIMIT) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end
                end
            end
            DRAIN: begin
                m_valid_o = 1'b1;
                if (m_ready_i) begin
                    if (out_end) begin
                        first_blk_d = blk_last_q;
                        state_d     = FILL;
                    end else begin
                        out_idx_d = out_idx_q + 4'd1;
                    end
                end
            end
            ERR: state_d = ERR;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FILL;
            byte_cnt_q  <= '0;
            out_idx_q   <= '0;
            nbytes_q    <= '0;
            first_blk_q <= 1'b1;
            blk_last_q  <= 1'b0;
            dec_q       <= 1'b0;
            chain_q     <= 1'b0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            wait_cnt_q  <= '0;
            data_q      <= '0;
            key_q       <= '0;
            iv_q        <= '0;
            result_q    <= '0;
            mode_q      <= '0;
            seg_q       <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            out_idx_q   <= out_idx_d;
            nbytes_q    <= nbytes_d;
            first_blk_q <= first_blk_d;
            blk_last_q  <= blk_last_d;
            dec_q       <= dec_d;
            chain_q     <= chain_d;
            ready_q     <= aes_ready_i;
            err_q       <= err_d;
            wait_cnt_q  <= wait_cnt_d;
            data_q      <= data_d;
            key_q       <= key_d;
            iv_q        <= iv_d;
            result_q    <= result_d;
            mode_q      <= mode_d;
            seg_q       <= seg_d;
        end
    end

    assign m_data_o          = result_q[7'd127 - {out_idx_q, 3'b000} -: 8];
    assign m_last_o          = (state_q == DRAIN) && blk_last_q && out_end;
    assign aes_chain_en_o    = (chain_q || state_q == LAUNCH) && state_q != CLR;
    assign aes_data_in_o     = data_q;
    assign aes_key_o         = key_q;
    assign aes_mode_o        = mode_q;
    assign aes_init_vector_o = iv_q;
    assign aes_segment_len_o = seg_q;
    assign busy_o            = !(state_q == FILL && byte_cnt_q == 4'd0);
    assign err_o             = err_q;

endmodule
